// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator: FSM state encodings,
// chip-enable levels and the default reset fetch address.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      PCG_OFF  = 2'd0,
      PCG_RUN  = 2'd1,
      PCG_HOLD = 2'd2,
      PCG_ERR  = 2'd3
   } pcg_state_e;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   localparam logic [31:0] PCG_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/pc_gen_redir_arbiter.sv
// Combinational redirect arbiter: lowest-index channel wins, with separate
// winners for forced (stall-bypassing) and normal channels.
module pc_redir_arbiter
   import pc_gen_pkg::*;
#(
   parameter int                   ADDR_W     = 32,
   parameter int                   NUM_REDIR  = 2,
   parameter logic [NUM_REDIR-1:0] FORCE_MASK = NUM_REDIR'(2'b01)
) (
   input  logic [NUM_REDIR-1:0]        redir_valid_i,
   input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
   output logic                        forced_hit,
   output logic [ADDR_W-1:0]           forced_addr,
   output logic                        norm_hit,
   output logic [ADDR_W-1:0]           norm_addr
);

   logic f_v_s;
   logic n_v_s;

   // Walk from the highest index down so the lowest valid index is written last.
   always_comb begin
      forced_hit  = 1'b0;
      forced_addr = '0;
      norm_hit    = 1'b0;
      norm_addr   = '0;
      f_v_s       = 1'b0;
      n_v_s       = 1'b0;
      for (int k = NUM_REDIR - 1; k >= 0; k--) begin
         f_v_s       = redir_valid_i[k] & FORCE_MASK[k];
         n_v_s       = redir_valid_i[k] & ~FORCE_MASK[k];
         forced_hit  = forced_hit | f_v_s;
         forced_addr = f_v_s ? redir_addr_i[k*ADDR_W +: ADDR_W] : forced_addr;
         norm_hit    = norm_hit | n_v_s;
         norm_addr   = n_v_s ? redir_addr_i[k*ADDR_W +: ADDR_W] : norm_addr;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator with prioritised redirects and stall-time pending capture.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                   ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC    = ADDR_W'(PCG_RESET_PC),
   parameter int                   FETCH_BYTES = 4,
   parameter int                   NUM_REDIR   = 2,
   parameter logic [NUM_REDIR-1:0] FORCE_MASK  = NUM_REDIR'(2'b01)
) (
   input  logic                        cpu_clk_75M,
   input  logic                        cpu_rst_n,
   input  logic                        stall_i,
   input  logic [NUM_REDIR-1:0]        redir_valid_i,
   input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
   input  logic                        fetch_gnt_i,
   output logic                        fetch_req_o,
   output logic [ADDR_W-1:0]           pc_o,
   output logic                        ce_o
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic                        addr_err_o
`endif
);

   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(FETCH_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(FETCH_BYTES);

   pcg_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              pend_v_q, pend_v_d;
   logic              ce_q, ce_d;
   logic              req_s, upd_s, load_s;
   logic [ADDR_W-1:0] tgt_s;
   logic              forced_hit_s, norm_hit_s;
   logic [ADDR_W-1:0] forced_addr_s, norm_addr_s;
`ifdef PC_ALIGN_CHECK_EN
   logic              err_q, err_d;
   logic              bad_s;
`endif

   pc_redir_arbiter #(
      .ADDR_W     (ADDR_W),
      .NUM_REDIR  (NUM_REDIR),
      .FORCE_MASK (FORCE_MASK)
   ) u_arb (
      .redir_valid_i (redir_valid_i),
      .redir_addr_i  (redir_addr_i),
      .forced_hit    (forced_hit_s),
      .forced_addr   (forced_addr_s),
      .norm_hit      (norm_hit_s),
      .norm_addr     (norm_addr_s)
   );

   assign req_s = ((state_q == PCG_RUN) || (state_q == PCG_HOLD)) & ~stall_i;
   assign upd_s = req_s & fetch_gnt_i;

   // Next-PC priority: forced redirect, then handshake-driven load/increment, else capture.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      ce_d        = ce_q;
      load_s      = 1'b0;
      tgt_s       = pc_q;
      case (state_q)
         PCG_OFF: begin
            state_d = PCG_RUN;
            ce_d    = ChipEnable;
         end
         PCG_RUN, PCG_HOLD: begin
            if (forced_hit_s) begin
               load_s   = 1'b1;
               tgt_s    = forced_addr_s;
               pend_v_d = 1'b0;
            end else if (upd_s) begin
               if (norm_hit_s) begin
                  load_s   = 1'b1;
                  tgt_s    = norm_addr_s;
                  pend_v_d = 1'b0;
               end else if (pend_v_q) begin
                  load_s   = 1'b1;
                  tgt_s    = pend_addr_q;
                  pend_v_d = 1'b0;
               end else begin
                  pc_d = pc_q + STEP;
               end
            end else if (norm_hit_s) begin
               pend_v_d    = 1'b1;
               pend_addr_d = norm_addr_s;
            end else begin
               pend_v_d = pend_v_q;
            end
            state_d = pend_v_d ? PCG_HOLD : PCG_RUN;
         end
         PCG_ERR: begin
`ifdef PC_ALIGN_CHECK_EN
            if (forced_hit_s) begin
               load_s   = 1'b1;
               tgt_s    = forced_addr_s;
               pend_v_d = 1'b0;
               state_d  = PCG_RUN;
            end else begin
               state_d = PCG_ERR;
            end
`else
            state_d = PCG_RUN;
`endif
         end
         default: begin
            state_d = PCG_OFF;
         end
      endcase
`ifdef PC_ALIGN_CHECK_EN
      // A misaligned target is loaded as-is and parks the block in ERR.
      pc_d    = load_s ? tgt_s : pc_d;
      bad_s   = load_s & (|(tgt_s & LOW_MASK));
      state_d = bad_s ? PCG_ERR : state_d;
      err_d   = bad_s | (~load_s & err_q);
`else
      pc_d    = load_s ? (tgt_s & ~LOW_MASK) : pc_d;
`endif
   end

   // State, PC and pending-redirect registers.
   always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q     <= PCG_OFF;
         pc_q        <= RESET_PC;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         ce_q        <= ChipDisable;
`ifdef PC_ALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
         ce_q        <= ce_d;
`ifdef PC_ALIGN_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign pc_o        = pc_q;
   assign ce_o        = ce_q;
   assign fetch_req_o = req_s;
`ifdef PC_ALIGN_CHECK_EN
   assign addr_err_o  = err_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; covers the PC_ALIGN_CHECK_EN build when defined.
module tb_pc_gen;
   import pc_gen_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [1:0]  rvalid;
   logic [63:0] raddr;
   logic        gnt;
   logic        req;
   logic [31:0] pc;
   logic        ce;
`ifdef PC_ALIGN_CHECK_EN
   logic        aerr;
`endif

   int checks = 0;
   int errors = 0;

   pc_gen dut (
      .cpu_clk_75M   (clk),
      .cpu_rst_n     (rst_n),
      .stall_i       (stall),
      .redir_valid_i (rvalid),
      .redir_addr_i  (raddr),
      .fetch_gnt_i   (gnt),
      .fetch_req_o   (req),
      .pc_o          (pc),
      .ce_o          (ce)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .addr_err_o    (aerr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic redir(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
      rvalid = v;
      raddr  = {a1, a0};
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; gnt = 1'b1;
      redir(2'b00, 32'h0, 32'h0);
      tick();
      chk("rst_pc", pc, 32'hBFC0_0000);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_req", 32'(req), 32'd0);
`ifdef PC_ALIGN_CHECK_EN
      chk("rst_err", 32'(aerr), 32'd0);
`endif
      rst_n = 1'b1;
      tick();
      chk("ce_up", 32'(ce), 32'd1);
      chk("req_up", 32'(req), 32'd1);
      chk("pc0", pc, 32'hBFC0_0000);
      tick(); chk("pc1", pc, 32'hBFC0_0004);
      tick(); chk("pc2", pc, 32'hBFC0_0008);

      // Grant withheld: address and request must stay put.
      gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("nognt_pc", pc, 32'hBFC0_0008);
         chk("nognt_req", 32'(req), 32'd1);
      end
      gnt = 1'b1;
      tick(); chk("gnt_back", pc, 32'hBFC0_000C);

      // Normal redirect during stall is held in pending.
      stall = 1'b1;
      redir(2'b10, 32'h0, 32'h8000_1000);
      tick();
      chk("hold_st", 32'(dut.state_q), 32'(PCG_HOLD));
      chk("hold_pc", pc, 32'hBFC0_000C);
      chk("hold_req", 32'(req), 32'd0);
      redir(2'b00, 32'h0, 32'h0);
      tick();
      chk("hold_pc2", pc, 32'hBFC0_000C);
      stall = 1'b0;
      tick();
      chk("pend_take", pc, 32'h8000_1000);
      chk("pend_st", 32'(dut.state_q), 32'(PCG_RUN));

      // Forced channel beats stall and wipes an older pending.
      stall = 1'b1;
      redir(2'b10, 32'h0, 32'h8000_3000);
      tick();
      chk("hold2_st", 32'(dut.state_q), 32'(PCG_HOLD));
      redir(2'b11, 32'h8000_0180, 32'h8000_2000);
      tick();
      chk("force_pc", pc, 32'h8000_0180);
      chk("force_st", 32'(dut.state_q), 32'(PCG_RUN));
      redir(2'b00, 32'h0, 32'h0);
      stall = 1'b0;
      tick();
      chk("after_force", pc, 32'h8000_0184);

      // Increment wraps at the top of the address space.
      redir(2'b01, 32'hFFFF_FFFC, 32'h0);
      tick(); chk("wrap_load", pc, 32'hFFFF_FFFC);
      redir(2'b00, 32'h0, 32'h0);
      tick(); chk("wrap", pc, 32'h0000_0000);

      // Newer pending overwrites older.
      stall = 1'b1;
      redir(2'b10, 32'h0, 32'h8000_5000);
      tick();
      redir(2'b10, 32'h0, 32'h8000_6000);
      tick();
      chk("ovw_pc", pc, 32'h0000_0000);
      redir(2'b00, 32'h0, 32'h0);
      stall = 1'b0;
      tick(); chk("ovw_take", pc, 32'h8000_6000);

      // No grant: normal redirect is captured; forced one loads anyway.
      gnt = 1'b0;
      redir(2'b10, 32'h0, 32'h8000_4000);
      tick();
      chk("ng_pc", pc, 32'h8000_6000);
      chk("ng_st", 32'(dut.state_q), 32'(PCG_HOLD));
      redir(2'b00, 32'h0, 32'h0);
      gnt = 1'b1;
      tick(); chk("ng_take", pc, 32'h8000_4000);
      gnt = 1'b0;
      redir(2'b01, 32'h8000_0200, 32'h0);
      tick(); chk("ng_force", pc, 32'h8000_0200);
      redir(2'b00, 32'h0, 32'h0);
      gnt = 1'b1;

      // Misaligned redirect target.
      redir(2'b10, 32'h0, 32'h8000_0002);
      tick();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis_pc", pc, 32'h8000_0002);
      chk("mis_err", 32'(aerr), 32'd1);
      chk("mis_req", 32'(req), 32'd0);
      redir(2'b10, 32'h0, 32'h8000_7000);
      tick();
      chk("err_pc", pc, 32'h8000_0002);
      chk("err_err", 32'(aerr), 32'd1);
      chk("err_req", 32'(req), 32'd0);
      redir(2'b01, 32'h8000_0180, 32'h0);
      tick();
      chk("rec_pc", pc, 32'h8000_0180);
      chk("rec_err", 32'(aerr), 32'd0);
      chk("rec_req", 32'(req), 32'd1);
      redir(2'b00, 32'h0, 32'h0);
`else
      chk("mis_pc", pc, 32'h8000_0000);
      redir(2'b00, 32'h0, 32'h0);
      tick();
      chk("mis_next", pc, 32'h8000_0004);
`endif

      // Asynchronous reset mid-operation.
      rst_n = 1'b0;
      #2;
      chk("arst_pc", pc, 32'hBFC0_0000);
      chk("arst_ce", 32'(ce), 32'd0);
      chk("arst_req", 32'(req), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("arel_ce", 32'(ce), 32'd1);
      chk("arel_pc", pc, 32'hBFC0_0000);
      tick();
      chk("arel_pc1", pc, 32'hBFC0_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator, the next generation of the front-end PC register. It produces the instruction-fetch address and a fetch request towards instruction memory, advancing only on a request/grant handshake. It arbitrates N prioritised redirect channels (exception and branch sources), some of which may override pipeline stall. A non-forced redirect that arrives during a stall is captured in a pending register, not dropped.

## Interface
- `ADDR_W`, 32: fetch address width.
- `RESET_PC`, 32'hBFC0_0000: address loaded at reset.
- `FETCH_BYTES`, 4: sequential increment. Power of two, ≥1.
- `NUM_REDIR`, 2: redirect channel count, ≥1. Channel 0 has the highest priority.
- `FORCE_MASK`, 'b01: channels whose redirect bypasses stall and handshake. Default: channel 0 = CP0.

Ports:
- `cpu_clk_75M`, in, 1: clock.
- `cpu_rst_n`, in, 1: reset, asynchronous, active-low.
- `stall_i`, in, 1: fetch-stage stall from CTRL.
- `redir_valid_i`, in, NUM_REDIR: per-channel redirect request.
- `redir_addr_i`, in, NUM_REDIR*ADDR_W: targets. Channel k occupies bits [k*ADDR_W +: ADDR_W].
- `fetch_gnt_i`, in, 1: instruction memory accepts the current request.
- `fetch_req_o`, out, 1: fetch request valid.
- `pc_o`, out, ADDR_W: current fetch address.
- `ce_o`, out, 1: instruction memory chip enable.
- `addr_err_o`, out, 1: misaligned fetch target. Present only with `PC_ALIGN_CHECK_EN`.

## Operation
- States:
  - OFF: in reset, or the first edge after reset release.
  - RUN: normal fetch.
  - HOLD: RUN with a pending redirect held.
  - ERR: misaligned target held; exists only with the macro.
- Transitions:
  - OFF→RUN on the first edge with `cpu_rst_n`=1.
  - RUN→HOLD when a redirect is captured into pending.
  - HOLD→RUN when pending is consumed or cleared.
  - Any state→ERR on a misaligned load.
  - ERR→RUN only on a forced redirect with an aligned target.
- `fetch_req_o` = (state ∈ {RUN, HOLD}) & ~`stall_i`.
- Define `upd` = `fetch_req_o` & `fetch_gnt_i`.
- Next-PC priority, evaluated each edge outside OFF:
  1. Forced channel valid: take the lowest-index forced target. Pending is cleared. This applies regardless of `stall_i` and `fetch_gnt_i`.
  2. Else if `upd`:
     - a non-forced channel is valid: take the lowest-index target and clear pending;
     - else pending is valid: take the pending target and clear it;
     - else `pc_o` + FETCH_BYTES, wrapping mod 2^ADDR_W.
  3. Else (no `upd`):
     - a non-forced channel is valid: pending ← lowest-index target, overwriting any older pending;
     - `pc_o` is held.
- `pc_o` is stable while `fetch_req_o`=1 and `fetch_gnt_i`=0.

## Timing
- Reset values:
  - `pc_o`=RESET_PC, `ce_o`=0, `fetch_req_o`=0, `addr_err_o`=0;
  - pending empty, state OFF.
- `ce_o` rises one cycle after reset release. `fetch_req_o` for RESET_PC is valid in that same cycle.
- Redirect latency is 1 cycle: a target presented with a qualifying condition at edge N appears on `pc_o` after edge N.
- A captured pending redirect appears on `pc_o` one cycle after the first `upd` cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Pending is lost.
- FETCH_BYTES increment wraps: ADDR_W'hFFFF_FFFC + 4 → 0.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - any loaded target with addr[log2(FETCH_BYTES)-1:0]≠0 is loaded unchanged into `pc_o`;
  - state becomes ERR, `addr_err_o`=1 (registered, same cycle as the new `pc_o`), `fetch_req_o`=0;
  - the block waits for a forced redirect.
- Macro undefined: low bits of all redirect targets are silently cleared, `addr_err_o` and ERR do not exist.

## Structure
- Shared defines file holds:
  - state encodings (PCG_OFF/RUN/HOLD/ERR);
  - ChipEnable/ChipDisable;
  - default RESET_PC.
- One sub-module, `pc_redir_arbiter`: combinational lowest-index priority select split by FORCE_MASK. It outputs `forced_hit`, `forced_addr`, `norm_hit` and `norm_addr`.

## Test plan
- Reset release, `fetch_gnt_i`=1, no stall.
  - Expect `ce_o`=1 next cycle.
  - Expect `pc_o` = BFC00000, BFC00004, BFC00008 on consecutive cycles.
- `fetch_gnt_i`=0 for 3 cycles at `pc_o`=BFC00008.
  - Expect `pc_o` held and `fetch_req_o`=1 throughout.
  - Expect BFC0000C one cycle after grant.
- `stall_i`=1; channel 1 redirect to 80001000 for one cycle.
  - Expect state HOLD and `pc_o` unchanged.
  - Expect `pc_o`=80001000 after the first cycle with stall low and grant high.
- Channels 0 and 1 valid together during a stall (targets 80000180 / 80002000).
  - Expect `pc_o`=80000180 next cycle and pending cleared.
- Wrap: force `pc_o`=FFFFFFFC with grant.
  - Expect 00000000.
- With macro: redirect to 80000002.
  - Expect `addr_err_o`=1 and `fetch_req_o`=0 until a forced redirect to 80000180.
- Without macro: the same redirect gives `pc_o`=80000000.
